// File: rtl/game_mm_regbank.sv
// Avalon-MM register bank: byte-writable output registers plus a
// debounced button port with sticky edge flags and a maskable interrupt.
module game_mm_regbank #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int N_OUT   = 4,
    parameter int IN_W    = 5,
    parameter int DEB_CYC = 50000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [ADDR_W-1:0]       avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [DATA_W/8-1:0]     avs_byteenable,
    input  logic [DATA_W-1:0]       avs_writedata,
    output logic [DATA_W-1:0]       avs_readdata,
    output logic                    avs_readdatavalid,
    input  logic [IN_W-1:0]         pio_in,
    output logic [N_OUT*DATA_W-1:0] out_regs,
    output logic [N_OUT-1:0]        out_strobe,
    output logic                    irq
);

    localparam int BE_W = DATA_W / 8;
    localparam int CW   = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);
    localparam logic [31:0] INFO32 = {16'(N_OUT), 16'(IN_W)};
    localparam logic [DATA_W-1:0] INFO = DATA_W'(INFO32);

    localparam logic [ADDR_W-1:0] A_STATE = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_EDGE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_MASK  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_INFO  = ADDR_W'(3);

    logic [IN_W-1:0]   sync1;
    logic [IN_W-1:0]   sync2;
    logic [IN_W-1:0]   deb;
    logic [CW-1:0]     cnt [IN_W];
    logic [IN_W-1:0]   accept;
    logic [IN_W-1:0]   rise;

    logic [IN_W-1:0]   edge_cap;
    logic [IN_W-1:0]   irq_mask;
    logic [IN_W-1:0]   clr;
    logic [DATA_W-1:0] out_q [N_OUT];
    logic [N_OUT-1:0]  out_hit;
    logic [DATA_W-1:0] rd_mux;
    logic              rd_take;

    always_comb begin
        accept = '0;
        for (int i = 0; i < IN_W; i++) begin
            accept[i] = (sync2[i] != deb[i]) && (cnt[i] == CNT_MAX);
        end
        // Accepting while sync2 is 1 means the debounced bit goes 0->1.
        rise = accept & sync2;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < IN_W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= pio_in;
            sync2 <= sync1;
            for (int i = 0; i < IN_W; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        out_hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_hit[k] = (avs_address == ADDR_W'(4 + k));
        end
    end

    always_comb begin
        clr = '0;
        if (avs_write && avs_address == A_EDGE) begin
            for (int i = 0; i < IN_W; i++) begin
                clr[i] = avs_writedata[i] & avs_byteenable[i/8];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (avs_address == A_STATE) begin
            rd_mux[IN_W-1:0] = deb;
        end else if (avs_address == A_EDGE) begin
            rd_mux[IN_W-1:0] = edge_cap;
        end else if (avs_address == A_MASK) begin
            rd_mux[IN_W-1:0] = irq_mask;
        end else if (avs_address == A_INFO) begin
            rd_mux = INFO;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (out_hit[k]) begin
                    rd_mux = out_q[k];
                end
            end
        end
    end

    // A write on the same edge as a read wins; the read is dropped.
    assign rd_take = avs_read && !avs_write;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            edge_cap          <= '0;
            irq_mask          <= '0;
            out_strobe        <= '0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            irq               <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            edge_cap          <= (edge_cap & ~clr) | rise;
            irq               <= |(edge_cap & irq_mask);
            out_strobe        <= avs_write ? out_hit : '0;
            avs_readdatavalid <= rd_take;
            if (rd_take) begin
                avs_readdata <= rd_mux;
            end
            if (avs_write && avs_address == A_MASK) begin
                for (int i = 0; i < IN_W; i++) begin
                    if (avs_byteenable[i/8]) begin
                        irq_mask[i] <= avs_writedata[i];
                    end
                end
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (avs_write && out_hit[k]) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (avs_byteenable[b]) begin
                            out_q[k][b*8 +: 8] <= avs_writedata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_regs[k*DATA_W +: DATA_W] = out_q[k];
    end

endmodule
